rv_pipe_follower: RTL and testbench

RV_PIPE_FOLLOWER -- requirements
Module: rv_pipe_follower

---
 rtl/rv_pipe_follower.sv | 120 ++++++++++++
 tb/tb_rv_pipe_follower.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_follower.sv
// rv_pipe_follower: shadow of an RV32I core pipeline tracking per-stage occupancy, legality and retirement.
// Optional PC continuity checker enabled by defining RV_PIPE_FOLLOWER_PC_CHECK_EN.
module rv_pipe_follower #(
    parameter int XLEN   = 32,
    parameter int STAGES = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    input  logic [STAGES-1:0] stall,
    input  logic [STAGES-1:0] flush,
    output logic [STAGES-1:0] st_valid,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_pc,
    output logic [31:0]       wb_inst,
    output logic              wb_illegal,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              pc_err
);
    function automatic logic legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;
            7'b1100111: legal = f3 == 3'b000;
            7'b1100011: legal = f3 != 3'b010 && f3 != 3'b011;
            7'b0000011: legal = f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
            7'b0100011: legal = f3 <= 3'b010;
            7'b0010011: legal = f3 == 3'b001 ? f7 == 7'b0000000 :
                                f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
            7'b0110011: legal = f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            7'b0001111: legal = f3 == 3'b000;
            7'b1110011: legal = i == 32'h0000_0073 || i == 32'h0010_0073;
            default:    legal = 1'b0;
        endcase
    endfunction

    logic [STAGES-1:0]           v, ill, hold, kill;
    logic [STAGES-1:0][XLEN-1:0] pc;
    logic [STAGES-1:0][31:0]     inst;

    // Hold propagates backwards from any stalled younger-facing stage; a flush kills its stage and all older-input stages.
    always_comb begin
        hold = '0;
        kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(stall >> k);
            kill[k] = |(flush >> k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= '0;
            ill  <= '0;
            pc   <= '0;
            inst <= '0;
        end else begin
            if (!hold[0]) begin
                v[0]    <= in_valid;
                pc[0]   <= in_pc;
                inst[0] <= in_inst;
                ill[0]  <= ~legal(in_inst);
            end
            for (int k = 1; k < STAGES; k++) begin
                if (!hold[k]) begin
                    v[k]    <= v[k-1] & ~hold[k-1];
                    pc[k]   <= pc[k-1];
                    inst[k] <= inst[k-1];
                    ill[k]  <= ill[k-1];
                end
            end
            for (int k = 0; k < STAGES; k++)
                if (kill[k]) v[k] <= 1'b0;
        end
    end

    assign st_valid   = rst ? '0 : v;
    assign wb_valid   = v[STAGES-1] & ~rst;
    assign wb_pc      = rst ? '0 : pc[STAGES-1];
    assign wb_inst    = rst ? '0 : inst[STAGES-1];
    assign wb_illegal = ill[STAGES-1] & ~rst;
    assign retire     = wb_valid & ~stall[STAGES-1] & ~flush[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) retire_cnt <= '0;
        else if (retire && !(&retire_cnt)) retire_cnt <= retire_cnt + 1'b1;
    end

`ifdef RV_PIPE_FOLLOWER_PC_CHECK_EN
    logic            exp_v, err, cflow;
    logic [XLEN-1:0] exp_pc;
    assign cflow = wb_inst[6:0] == 7'b1101111 || wb_inst[6:0] == 7'b1100111 ||
                   wb_inst[6:0] == 7'b1100011 || wb_inst[6:0] == 7'b1110011 ||
                   wb_inst[6:0] == 7'b0001111;
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_v  <= 1'b0;
            exp_pc <= '0;
            err    <= 1'b0;
        end else begin
            if (retire && exp_v && wb_pc != exp_pc) err <= 1'b1;
            if (|flush) exp_v <= 1'b0;
            else if (retire) begin
                exp_v  <= ~cflow;
                exp_pc <= wb_pc + XLEN'(4);
            end
        end
    end
    assign pc_err = err;
`else
    assign pc_err = 1'b0;
`endif
endmodule

// File: tb/tb_rv_pipe_follower.sv
// tb_rv_pipe_follower: directed scoreboard bench for rv_pipe_follower (STAGES=6, CNT_W=4).
module tb_rv_pipe_follower;
    localparam int S = 6;

    logic          clk = 1'b0;
    logic          rst, in_valid;
    logic [31:0]   in_pc, in_inst;
    logic [S-1:0]  stall, flush, st_valid;
    logic          wb_valid, wb_illegal, retire, pc_err;
    logic [31:0]   wb_pc, wb_inst;
    logic [3:0]    retire_cnt;

    typedef struct {logic [31:0] pc; logic [31:0] inst; logic ill;} exp_t;
    exp_t q[$];
    exp_t e;
    int   vecs = 0, miss = 0;
    int   exp_cnt = 0;
    logic exp_err;

    rv_pipe_follower #(.XLEN(32), .STAGES(S), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .stall(stall), .flush(flush), .st_valid(st_valid), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_illegal(wb_illegal), .retire(retire),
        .retire_cnt(retire_cnt), .pc_err(pc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks any retirement against the scoreboard, then advances one clock.
    task automatic cyc();
        #1;
        if (retire) begin
            if (q.size() == 0) chk("retire_unexpected", {63'd0, retire}, 64'd0);
            else begin
                e = q.pop_front();
                chk("wb_pc", {32'd0, wb_pc}, {32'd0, e.pc});
                chk("wb_inst", {32'd0, wb_inst}, {32'd0, e.inst});
                chk("wb_illegal", {63'd0, wb_illegal}, {63'd0, e.ill});
                exp_cnt = exp_cnt == 15 ? 15 : exp_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic ill, input bit push);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        if (push) q.push_back('{pc, inst, ill});
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        stall    = '0;
        flush    = '0;
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
        chk("drain", 64'(q.size()), 64'd0);
        chk("retire_cnt", {60'd0, retire_cnt}, 64'(exp_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        q.delete();
        exp_cnt = 0;
        rst = 1'b0;
    endtask

    logic [32:0] ill_tab [15] = '{
        {1'b1, 32'h0200_0033}, {1'b1, 32'h0020_0073}, {1'b0, 32'h4000_5013},
        {1'b0, 32'h0000_2003}, {1'b1, 32'h0000_3003}, {1'b1, 32'h4000_1013},
        {1'b1, 32'h0000_2063}, {1'b0, 32'h0000_0067}, {1'b0, 32'h4000_0033},
        {1'b1, 32'h4000_1033}, {1'b0, 32'h0000_0073}, {1'b0, 32'h0010_0073},
        {1'b1, 32'h0000_300f}, {1'b0, 32'h0000_2023}, {1'b1, 32'h0000_3023}};

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h55; in_inst = 32'h13;
        stall = '1; flush = '1;
        cyc();
        cyc();
        #1;
        chk("rst_st_valid", 64'(st_valid), 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_pc", {32'd0, wb_pc}, 64'd0);
        chk("rst_wb_inst", {32'd0, wb_inst}, 64'd0);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        chk("rst_cnt", {60'd0, retire_cnt}, 64'd0);
        chk("rst_pc_err", {63'd0, pc_err}, 64'd0);
        rst = 1'b0; in_valid = 1'b0; stall = '0; flush = '0;

        // single ADDI, six-cycle latency
        send(32'h100, 32'h0010_0093, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("lat_wait", {63'd0, wb_valid}, 64'd0);
            cyc();
        end
        chk("lat_wb_valid", {63'd0, wb_valid}, 64'd1);
        chk("lat_retire", {63'd0, retire}, 64'd1);
        cyc();
        chk("lat_cnt", {60'd0, retire_cnt}, 64'd1);

        // legality decode, back-to-back stream
        for (int i = 0; i < 15; i++)
            send(32'h104 + 32'(4 * i), ill_tab[i][31:0], ill_tab[i][32], 1'b1);
        drain();

        // stall[3] for two cycles; in_valid during hold must be dropped
        for (int i = 0; i < 4; i++) send(32'h300 + 32'(4 * i), 32'h0010_0093, 1'b0, 1'b1);
        stall = 6'b001000;
        in_valid = 1'b1; in_pc = 32'hdead; in_inst = 32'h0000_0013;
        cyc();
        chk("stall_st_valid1", 64'(st_valid), 64'h0f);
        cyc();
        chk("stall_st_valid2", 64'(st_valid), 64'h0f);
        drain();

        // full pipe, flush[2] while held
        for (int i = 0; i < 6; i++) send(32'h400 + 32'(4 * i), 32'h0000_0033, 1'b0, i < 3);
        chk("full_st_valid", 64'(st_valid), 64'h3f);
        stall = 6'b100000;
        flush = 6'b000100;
        cyc();
        chk("flush_st_valid", 64'(st_valid), 64'h38);
        drain();

        // multiple flush bits act as the highest one
        for (int i = 0; i < 6; i++) send(32'h500 + 32'(4 * i), 32'h0000_0033, 1'b0, i < 1);
        stall = 6'b100000;
        flush = 6'b010001;
        cyc();
        chk("mflush_st_valid", 64'(st_valid), 64'h20);
        drain();

        // saturation of the 4-bit counter
        for (int i = 0; i < 6; i++) send(32'h600 + 32'(4 * i), 32'h0010_0093, 1'b0, 1'b1);
        drain();
        chk("cnt_saturated", {60'd0, retire_cnt}, 64'd15);

        // reset mid-stream
        for (int i = 0; i < 3; i++) send(32'h700 + 32'(4 * i), 32'h0010_0093, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1;
        #1;
        chk("mrst_st_valid", 64'(st_valid), 64'd0);
        chk("mrst_retire", {63'd0, retire}, 64'd0);
        cyc();
        chk("mrst_cnt", {60'd0, retire_cnt}, 64'd0);
        chk("mrst_wb_pc", {32'd0, wb_pc}, 64'd0);
        rst = 1'b0; in_valid = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 8; i++) cyc();
        send(32'h800, 32'h0010_0093, 1'b0, 1'b1);
        drain();

        // PC continuity
`ifdef RV_PIPE_FOLLOWER_PC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        send(32'h200, 32'h0000_0033, 1'b0, 1'b1);
        send(32'h208, 32'h0000_0033, 1'b0, 1'b1);
        drain();
        chk("pc_err_set", {63'd0, pc_err}, {63'd0, exp_err});
        for (int i = 0; i < 3; i++) cyc();
        chk("pc_err_sticky", {63'd0, pc_err}, {63'd0, exp_err});
        do_reset();
        send(32'h200, 32'h0000_006f, 1'b0, 1'b1);
        send(32'h300, 32'h0000_0033, 1'b0, 1'b1);
        drain();
        chk("pc_err_jal", {63'd0, pc_err}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
